anchor_sequencer: RTL

Parametrised successor to the filter-phase controller. It raster-walks a processing anchor across the image with a configurable stride, margin and stage count, and advances only when every pipeline stage reports completion. It latches the image geometry at start, supports abort, and produces read/write enables plus a one-cycle completion pulse. It sits between the top-level sequencer (start/abort) and the SRAM I/O, blur, gradient, NMS and hysteresis stages.

---
 rtl/edge_pkg.sv | 16 +
 rtl/step_counter.sv | 41 ++++
 rtl/anchor_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/edge_pkg.sv
// rtl/edge_pkg.sv - shared state type and default parameters for the anchor sequencer
package edge_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PROCESSING = 2'd1,
    DONE       = 2'd2
  } seq_state_t;

  localparam int COORD_W_DEF    = 16;
  localparam int NUM_STAGES_DEF = 5;
  localparam int STEP_X_DEF     = 1;
  localparam int STEP_Y_DEF     = 1;
  localparam int X_OFFSET_DEF   = 4;

endpackage

// File: rtl/step_counter.sv
// rtl/step_counter.sv - strided coordinate counter that wraps to 0 once count+STEP reaches limit
module step_counter #(
  parameter int WIDTH = 16,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH:0]   limit,
  output logic [WIDTH-1:0] count,
  output logic             at_last
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH:0]   sum;

  // One extra bit so count+STEP can never wrap past limit unnoticed
  assign sum     = {1'b0, count_q} + (WIDTH+1)'(STEP);
  assign at_last = (sum >= limit);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = at_last ? '0 : sum[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/anchor_sequencer.sv
// rtl/anchor_sequencer.sv - raster-walks the processing anchor, advancing when every stage is final
// Optional stall counter enabled by defining ANCHOR_SEQ_STALL_CNT_EN.
module anchor_sequencer
  import edge_pkg::*;
#(
  parameter int COORD_W    = COORD_W_DEF,
  parameter int NUM_STAGES = NUM_STAGES_DEF,
  parameter int STEP_X     = STEP_X_DEF,
  parameter int STEP_Y     = STEP_Y_DEF,
  parameter int X_OFFSET   = X_OFFSET_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_STAGES-1:0] stage_final,
  input  logic [COORD_W-1:0]    width,
  input  logic [COORD_W-1:0]    height,
  output logic                  read_enable,
  output logic                  write_enable,
  output logic                  anchor_moving,
  output logic [COORD_W-1:0]    anchor_x,
  output logic [COORD_W-1:0]    anchor_y,
  output logic                  busy,
  output logic                  process_done,
  output logic [31:0]           stall_count
);

  seq_state_t         state_q, state_d;
  logic [COORD_W-1:0] width_q, height_q;
  logic [COORD_W:0]   x_end;
  logic               all_final, last_x, last_y;
  logic               start_ok, clear_anchor, done_q;

  assign all_final     = &stage_final;
  assign start_ok      = (state_q == IDLE) && start && !abort;
  assign x_end         = {1'b0, width_q} + (COORD_W+1)'(X_OFFSET);
  assign anchor_moving = (state_q == PROCESSING) && all_final && !(last_x && last_y);
  // Counters sit at (0,0) whenever the walk is not running, so IDLE always shows the origin
  assign clear_anchor  = abort || (state_q != PROCESSING);

  step_counter #(.WIDTH(COORD_W), .STEP(STEP_X)) u_x (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear_anchor),
    .enable  (anchor_moving),
    .limit   (x_end),
    .count   (anchor_x),
    .at_last (last_x)
  );

  step_counter #(.WIDTH(COORD_W), .STEP(STEP_Y)) u_y (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear_anchor),
    .enable  (anchor_moving && last_x),
    .limit   ({1'b0, height_q}),
    .count   (anchor_y),
    .at_last (last_y)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = (width == '0 || height == '0) ? DONE : PROCESSING;
        end
      end
      PROCESSING: begin
        if (all_final && last_x && last_y) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      width_q  <= '0;
      height_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == DONE);
      if (start_ok) begin
        width_q  <= width;
        height_q <= height;
      end
    end
  end

  assign busy         = (state_q != IDLE);
  assign read_enable  = (state_q == PROCESSING);
  assign process_done = done_q;
  assign write_enable = anchor_moving && ({1'b0, anchor_x} >= (COORD_W+1)'(X_OFFSET));

`ifdef ANCHOR_SEQ_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (start_ok) begin
      stall_q <= '0;
    end else if ((state_q == PROCESSING) && !all_final && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

endmodule
